icache_fill_unit: RTL and testbench

- Instruction-side responder to the fetch stage: answers imemREN/imemaddr with ihit/imemload, which the hazard unit consumes to decide IF/ID stalls.
- Direct-mapped, 8 sets x 2-word blocks. A miss runs a 2-beat fill over the iREN/iaddr/iwait/iload port to the memory controller.
- Adds whole-cache invalidate and saturating hit/miss performance counters.

---
 rtl/icache_fill_unit_pkg.sv | 33 +++
 rtl/icache_fill_unit_if.sv | 26 ++
 rtl/icache_fill_unit_sat_counter.sv | 22 ++
 rtl/icache_fill_unit.sv | 120 ++++++++++++
 tb/tb_icache_fill_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_fill_unit_pkg.sv
// Shared cache definitions for the instruction cache. The data cache reuses these too.
//   ICACHE_SETS / IWORDS    : default geometry (8 sets x 2 words)
//   IIDX_W / ITAG_W         : index and tag widths for the default geometry
//   icachef_t               : field overlay of a 32-bit byte address
//   icache_frame_t          : one cache frame (valid, tag, block data)
//   icache_state_t          : fill FSM states
package icache_fill_unit_pkg;

    localparam int unsigned ICACHE_SETS = 8;
    localparam int unsigned IWORDS      = 2;
    localparam int unsigned IIDX_W      = $clog2(ICACHE_SETS);
    localparam int unsigned ITAG_W      = 32 - IIDX_W - 3;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic              blkoff;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic                   valid;
        logic [ITAG_W-1:0]      tag;
        logic [IWORDS-1:0][31:0] data;
    } icache_frame_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_fill_unit_if.sv
// Fetch-side and memory-side signals of the instruction cache.
//   imemREN/imemaddr -> ihit/imemload   : fetch request and response
//   iREN/iaddr       -> iload/iwait     : fill port toward the memory controller
//   invalidate                          : whole-cache invalidate pulse
// slave is the cache's view; master is the view of its environment.
interface icache_fill_unit_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        invalidate;

    modport slave (
        input  imemREN, imemaddr, iload, iwait, invalidate,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iload, iwait, invalidate,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_fill_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
//   CLK, nRST : clock, synchronous active-low reset
//   en        : count this edge
//   count     : current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/icache_fill_unit.sv
// Direct-mapped instruction cache with a two-beat block fill, whole-cache invalidate and
// saturating hit/miss counters.
//   CLK, nRST           : clock, synchronous active-low reset
//   bus (slave)         : fetch request/response and memory fill port
//   hitcount, misscount : saturating performance counters
module icache_fill_unit
    import icache_fill_unit_pkg::*;
#(
    parameter int unsigned SETS  = ICACHE_SETS,
    parameter int unsigned WORDS = IWORDS,
    parameter int unsigned CNTW  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    icache_fill_unit_if.slave bus,
    output logic [CNTW-1:0]   hitcount,
    output logic [CNTW-1:0]   misscount
);

    localparam int unsigned IDXW = $clog2(SETS);
    localparam int unsigned TAGW = 32 - IDXW - 3;

    icache_state_t   state_q, state_d;
    logic            pending_inv_q, pending_inv_d;
    logic [SETS-1:0] valid_q, valid_d;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS][WORDS];
    logic [TAGW-1:0] fill_tag_q;
    logic [IDXW-1:0] fill_idx_q;

    logic [IDXW-1:0] req_idx;
    logic [TAGW-1:0] req_tag;
    logic            req_word;
    logic            hit, miss_start, beat0_done, fill_done;
    logic            unused_bytoff;

    assign req_idx       = bus.imemaddr[IDXW+2:3];
    assign req_tag       = bus.imemaddr[31:IDXW+3];
    assign req_word      = bus.imemaddr[2];
    assign unused_bytoff = ^bus.imemaddr[1:0];

    always_comb begin
        hit = bus.imemREN && (state_q == IDLE) && valid_q[req_idx] &&
              (tag_q[req_idx] == req_tag) && !pending_inv_q && !bus.invalidate;
        // A request that lands on an invalidate cycle retries next cycle instead of filling now.
        miss_start = bus.imemREN && (state_q == IDLE) && !hit && !pending_inv_q &&
                     !bus.invalidate;
        beat0_done = (state_q == FILL0) && !bus.iwait;
        fill_done  = (state_q == FILL1) && !bus.iwait;

        bus.ihit     = hit;
        bus.imemload = hit ? data_q[req_idx][req_word] : '0;
        bus.iREN     = (state_q == FILL0) || (state_q == FILL1);
        bus.iaddr    = '0;
        if (state_q == FILL0) bus.iaddr = {fill_tag_q, fill_idx_q, 1'b0, 2'b00};
        if (state_q == FILL1) bus.iaddr = {fill_tag_q, fill_idx_q, 1'b1, 2'b00};
    end

    always_comb begin
        state_d       = state_q;
        pending_inv_d = pending_inv_q;
        valid_d       = valid_q;
        unique case (state_q)
            IDLE:    if (miss_start) state_d = FILL0;
            FILL0:   if (!bus.iwait) state_d = FILL1;
            FILL1:   if (!bus.iwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // An invalidate seen mid-fill is deferred so the fill still finishes cleanly.
        if (bus.invalidate && (state_q != IDLE)) pending_inv_d = 1'b1;
        if (fill_done) pending_inv_d = 1'b0;

        if (fill_done && !pending_inv_q && !bus.invalidate) valid_d[fill_idx_q] = 1'b1;
        if ((bus.invalidate && (state_q == IDLE)) ||
            (fill_done && (pending_inv_q || bus.invalidate))) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= IDLE;
            pending_inv_q <= 1'b0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            pending_inv_q <= pending_inv_d;
            valid_q       <= valid_d;
        end
    end

    // Tags and data carry no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (miss_start) begin
            fill_tag_q <= req_tag;
            fill_idx_q <= req_idx;
        end
        if (beat0_done) data_q[fill_idx_q][1'b0] <= bus.iload;
        if (fill_done) begin
            data_q[fill_idx_q][1'b1] <= bus.iload;
            tag_q[fill_idx_q]        <= fill_tag_q;
        end
    end

    sat_counter #(.W(CNTW)) u_hitcnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (hit),
        .count (hitcount)
    );

    sat_counter #(.W(CNTW)) u_misscnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .en    (miss_start),
        .count (misscount)
    );

endmodule

// File: tb/tb_icache_fill_unit.sv
module tb_icache_fill_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] hitcount, misscount;
    logic [1:0]  hc2, mc2;

    icache_fill_unit_if ifm ();
    icache_fill_unit_if ifs ();

    int          total = 0;
    int          bad   = 0;
    int          wait_n = 0;
    int          beat_cnt = 0;
    int          exp_hits = 0;
    int          exp_miss = 0;
    logic [31:0] exp_q  [$];
    logic [31:0] beat_q [$];
    bit          m_valid [8];
    logic [25:0] m_tag   [8];

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010000;
        if (a == 32'h44) return 32'h8C020004;
        return a ^ 32'hA5C30000;
    endfunction

    assign ifm.iload = memword(ifm.iaddr);
    assign ifm.iwait = ifm.iREN && (beat_cnt < wait_n);

    // Second instance with 2-bit counters sees identical stimulus, to reach saturation quickly.
    assign ifs.imemREN    = ifm.imemREN;
    assign ifs.imemaddr   = ifm.imemaddr;
    assign ifs.invalidate = ifm.invalidate;
    assign ifs.iwait      = ifm.iwait;
    assign ifs.iload      = memword(ifs.iaddr);

    icache_fill_unit u_dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (ifm),
        .hitcount  (hitcount),
        .misscount (misscount)
    );

    icache_fill_unit #(.CNTW(2)) u_small (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (ifs),
        .hitcount  (hc2),
        .misscount (mc2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (ifm.iREN === 1'b1 && ifm.iwait === 1'b1) beat_cnt <= beat_cnt + 1;
        else beat_cnt <= 0;
        if (ifm.iREN === 1'b1 && ifm.iwait === 1'b0) beat_q.push_back(ifm.iaddr);
    end

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tg, obs, exp);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[a[5:3]] && (m_tag[a[5:3]] == a[31:6]);
    endfunction

    task automatic model_fill(input logic [31:0] a);
        m_valid[a[5:3]] = 1'b1;
        m_tag[a[5:3]]   = a[31:6];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    task automatic chk_counts(input string tg);
        chk({tg, "_hitcnt"}, hitcount, exp_hits);
        chk({tg, "_misscnt"}, misscount, exp_miss);
        chk({tg, "_hitcnt2"}, {30'd0, hc2}, sat3(exp_hits));
        chk({tg, "_misscnt2"}, {30'd0, mc2}, sat3(exp_miss));
    endtask

    // Waits for ihit (bounded), pops the scoreboard and checks data and latency.
    task automatic wait_hit(input string tg, input int exp_lat);
        int          cyc;
        logic [31:0] want;
        cyc = 0;
        @(negedge CLK);
        while (ifm.ihit !== 1'b1 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
        end
        want = exp_q.pop_front();
        chk({tg, "_ihit"}, {31'd0, ifm.ihit}, 32'd1);
        chk({tg, "_lat"}, cyc, exp_lat);
        chk({tg, "_data"}, ifm.imemload, want);
        @(posedge CLK);
        #1;
        exp_hits++;
    endtask

    task automatic fetch(input string tg, input logic [31:0] a);
        bit h;
        int nb;
        h  = model_hit(a);
        nb = beat_q.size();
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = a;
        exp_q.push_back(memword(a));
        wait_hit(tg, h ? 0 : 3 + 2 * wait_n);
        ifm.imemREN = 1'b0;
        if (!h) begin
            exp_miss++;
            model_fill(a);
            chk({tg, "_beats"}, beat_q.size(), nb + 2);
            chk({tg, "_beat0"}, beat_q[nb], {a[31:3], 3'b000});
            chk({tg, "_beat1"}, beat_q[nb+1], {a[31:3], 3'b100});
        end
        chk_counts(tg);
    endtask

    task automatic run_until_beats(input int n, output bit saw);
        int cyc;
        cyc = 0;
        saw = 1'b0;
        while (beat_q.size() < n && cyc < 60) begin
            @(negedge CLK);
            if (ifm.ihit === 1'b1) saw = 1'b1;
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int nb;
        nRST           = 1'b0;
        ifm.imemREN    = 1'b0;
        ifm.imemaddr   = '0;
        ifm.invalidate = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_ihit", {31'd0, ifm.ihit}, 32'd0);
        chk("rst_iren", {31'd0, ifm.iREN}, 32'd0);
        chk("rst_iaddr", ifm.iaddr, 32'd0);
        chk("rst_imemload", ifm.imemload, 32'd0);
        chk_counts("rst");
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // Cold miss then spatial hit
        fetch("cold40", 32'h40);
        chk("cold40_misscnt_const", misscount, 32'd1);
        fetch("spat44", 32'h44);
        chk("spat44_misscnt_const", misscount, 32'd1);

        // Conflict eviction on index 0
        fetch("conf80", 32'h80);
        fetch("conf40", 32'h40);
        chk("conf_misscnt_const", misscount, 32'd3);

        // Stretched fill with the fetch address switched after the first beat
        wait_n = 4;
        nb = beat_q.size();
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = 32'h100;
        run_until_beats(nb + 1, saw);
        chk("str_nohit0", {31'd0, saw}, 32'd0);
        ifm.imemaddr = 32'h200;
        run_until_beats(nb + 2, saw);
        chk("str_nohit1", {31'd0, saw}, 32'd0);
        chk("str_beats", beat_q.size(), nb + 2);
        chk("str_beat0", beat_q[nb], 32'h100);
        chk("str_beat1", beat_q[nb+1], 32'h104);
        exp_miss++;
        model_fill(32'h100);
        fetch("str100", 32'h100);
        fetch("str200", 32'h200);
        wait_n = 0;

        // Invalidate pulse in FILL1 while memory is still busy
        fetch("pre40", 32'h40);
        wait_n = 2;
        nb = beat_q.size();
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = 32'h1C8;
        run_until_beats(nb + 1, saw);
        ifm.invalidate = 1'b1;
        ifm.imemREN    = 1'b0;
        @(posedge CLK);
        #1;
        ifm.invalidate = 1'b0;
        run_until_beats(nb + 2, saw);
        chk("inv_nohit", {31'd0, saw}, 32'd0);
        chk("inv_beat1", beat_q[nb+1], 32'h1CC);
        chk("inv_iren", {31'd0, ifm.iREN}, 32'd0);
        exp_miss++;
        model_clear();
        wait_n = 0;
        fetch("inv40", 32'h40);
        fetch("inv1c8", 32'h1C8);

        // Invalidate on the same edge as the final beat
        nb = beat_q.size();
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = 32'h1D0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        ifm.invalidate = 1'b1;
        ifm.imemREN    = 1'b0;
        @(posedge CLK);
        #1;
        ifm.invalidate = 1'b0;
        chk("same_beat1", beat_q[nb+1], 32'h1D4);
        exp_miss++;
        model_clear();
        fetch("same1d0", 32'h1D0);
        fetch("same40", 32'h40);

        // Held hit during a stall counts every cycle
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = 32'h1D4;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(memword(32'h1D4));
            @(negedge CLK);
            chk("stall_ihit", {31'd0, ifm.ihit}, 32'd1);
            chk("stall_data", ifm.imemload, exp_q.pop_front());
            @(posedge CLK);
            #1;
            exp_hits++;
        end
        ifm.imemREN = 1'b0;
        chk_counts("stall");
        chk("sat_hit_const", {30'd0, hc2}, 32'd3);
        chk("sat_miss_const", {30'd0, mc2}, 32'd3);

        // Reset in the middle of a fill
        wait_n = 4;
        ifm.imemREN  = 1'b1;
        ifm.imemaddr = 32'h300;
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        chk("mrst_iren", {31'd0, ifm.iREN}, 32'd0);
        chk("mrst_iaddr", ifm.iaddr, 32'd0);
        chk("mrst_ihit", {31'd0, ifm.ihit}, 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        model_clear();
        chk_counts("mrst");
        ifm.imemREN = 1'b0;
        nRST = 1'b1;
        wait_n = 0;
        @(posedge CLK);
        #1;
        fetch("post40", 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
